// File: rtl/rv_pbus_arb.sv
// rv_pbus_arb: round-robin arbiter sharing rv32_core's host memory port among NREQ masters.
// Optional p_ack watchdog (sticky tmo_err) is built when RV_PBUS_ARB_TIMEOUT_EN is defined.
module rv_pbus_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned TMO  = 256
) (
  input  logic               cclk,
  input  logic               xreset,
  input  logic [NREQ-1:0]    req_re,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*32-1:0] req_adr,
  input  logic [NREQ*32-1:0] req_dw,
  output logic [NREQ-1:0]    req_ack,
  output logic [31:0]        req_dr,
  output logic [31:0]        p_adr,
  output logic               p_we,
  output logic               p_re,
  output logic [31:0]        p_dw,
  input  logic [31:0]        p_dr,
  input  logic               p_ack,
  output logic               tmo_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TMO == 0) begin : g_bad_param
    $error("rv_pbus_arb: NREQ must be 2..8 and TMO must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [DW-1:0]   p_adr_q, p_adr_d;
  logic [DW-1:0]   p_dw_q, p_dw_d;
  logic            p_we_q, p_we_d;
  logic            p_re_q, p_re_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [DW-1:0]   req_dr_q, req_dr_d;

`ifdef RV_PBUS_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tmo_err_q, tmo_err_d;
`endif

  // Flat request vectors reshaped per master
  logic [DW-1:0]   adr_arr [NREQ];
  logic [DW-1:0]   dw_arr  [NREQ];
  logic [NREQ-1:0] active;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign adr_arr[g] = req_adr[g*DW +: DW];
    assign dw_arr[g]  = req_dw[g*DW +: DW];
  end

  assign active = req_re | req_we;

  // Round-robin pick: first active index after the last grant, wrapping
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;

  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (!gnt_vld && active[IW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    p_adr_d   = p_adr_q;
    p_dw_d    = p_dw_q;
    p_we_d    = p_we_q;
    p_re_d    = p_re_q;
    req_ack_d = '0;
    req_dr_d  = req_dr_q;
`ifdef RV_PBUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_err_d = tmo_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = BUSY;
          last_d  = gnt_idx;
          p_adr_d = adr_arr[gnt_idx];
          p_dw_d  = dw_arr[gnt_idx];
          p_we_d  = req_we[gnt_idx];
          p_re_d  = req_re[gnt_idx] & ~req_we[gnt_idx];
`ifdef RV_PBUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef RV_PBUS_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (p_ack) begin
          state_d           = ACK;
          req_dr_d          = p_dr;
          p_we_d            = 1'b0;
          p_re_d            = 1'b0;
          req_ack_d[last_q] = 1'b1;
`ifdef RV_PBUS_ARB_TIMEOUT_EN
        end else if (cnt_d == CW'(TMO)) begin
          // Core never answered: complete with a poison value and flag it
          state_d           = ACK;
          req_dr_d          = 32'hDEAD_BEEF;
          p_we_d            = 1'b0;
          p_re_d            = 1'b0;
          req_ack_d[last_q] = 1'b1;
          tmo_err_d         = 1'b1;
`endif
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      p_adr_q   <= '0;
      p_dw_q    <= '0;
      p_we_q    <= 1'b0;
      p_re_q    <= 1'b0;
      req_ack_q <= '0;
      req_dr_q  <= '0;
`ifdef RV_PBUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      p_adr_q   <= p_adr_d;
      p_dw_q    <= p_dw_d;
      p_we_q    <= p_we_d;
      p_re_q    <= p_re_d;
      req_ack_q <= req_ack_d;
      req_dr_q  <= req_dr_d;
`ifdef RV_PBUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign p_adr   = p_adr_q;
  assign p_dw    = p_dw_q;
  assign p_we    = p_we_q;
  assign p_re    = p_re_q;
  assign req_ack = req_ack_q;
  assign req_dr  = req_dr_q;
`ifdef RV_PBUS_ARB_TIMEOUT_EN
  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_pbus_arb.sv
// Directed bench for rv_pbus_arb: vector table of single transactions plus
// hand-written sequences for alternation, mid-transaction reset and the ack watchdog.
module tb_rv_pbus_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TMO  = 16;

  logic               cclk = 1'b0;
  logic               xreset;
  logic [NREQ-1:0]    req_re, req_we;
  logic [NREQ*32-1:0] req_adr, req_dw;
  logic [NREQ-1:0]    req_ack;
  logic [31:0]        req_dr, p_adr, p_dw, p_dr;
  logic               p_we, p_re, p_ack, tmo_err;

  rv_pbus_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
    .cclk(cclk), .xreset(xreset),
    .req_re(req_re), .req_we(req_we), .req_adr(req_adr), .req_dw(req_dw),
    .req_ack(req_ack), .req_dr(req_dr),
    .p_adr(p_adr), .p_we(p_we), .p_re(p_re), .p_dw(p_dw),
    .p_dr(p_dr), .p_ack(p_ack), .tmo_err(tmo_err)
  );

  always #5 cclk = ~cclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  re, we;
    logic [31:0] adr0, adr1, dw0, dw1;
    int          wait_cyc;
    logic [31:0] pdr;
    logic [1:0]  e_ack;
    logic [31:0] e_adr, e_dw;
    logic        e_we, e_re;
  } vec_t;

  vec_t vecs [6];

  // One transaction: request at a negedge, core acks after wait_cyc idle BUSY cycles
  task automatic run_vec(input int id, input vec_t v);
    int hold_ok;
    req_re  = v.re;
    req_we  = v.we;
    req_adr = {v.adr1, v.adr0};
    req_dw  = {v.dw1, v.dw0};
    @(posedge cclk); @(negedge cclk);
    chk($sformatf("v%0d p_adr", id), p_adr, v.e_adr);
    chk($sformatf("v%0d p_dw", id), p_dw, v.e_dw);
    chk($sformatf("v%0d p_we", id), 32'(p_we), 32'(v.e_we));
    chk($sformatf("v%0d p_re", id), 32'(p_re), 32'(v.e_re));
    chk($sformatf("v%0d early ack", id), 32'(req_ack), 32'(0));
    hold_ok = 0;
    for (int i = 0; i <= v.wait_cyc; i++) begin
      if (p_adr === v.e_adr && p_dw === v.e_dw && p_we === v.e_we && p_re === v.e_re)
        hold_ok++;
      if (i == v.wait_cyc) begin
        p_ack = 1'b1;
        p_dr  = v.pdr;
      end
      @(posedge cclk); @(negedge cclk);
    end
    p_ack = 1'b0;
    p_dr  = '0;
    chk($sformatf("v%0d busy hold cycles", id), 32'(hold_ok), 32'(v.wait_cyc + 1));
    chk($sformatf("v%0d req_ack", id), 32'(req_ack), 32'(v.e_ack));
    chk($sformatf("v%0d req_dr", id), req_dr, v.pdr);
    chk($sformatf("v%0d p_we|p_re after ack", id), 32'(p_we | p_re), 32'(0));
    req_re = '0;
    req_we = '0;
    @(posedge cclk); @(negedge cclk);
    chk($sformatf("v%0d ack one cycle", id), 32'(req_ack), 32'(0));
    chk($sformatf("v%0d req_dr held", id), req_dr, v.pdr);
  endtask

  int          grants [4];
  int          n_gnt;
  int          busy_cyc;
  logic        got_ack;
  vec_t        vw;

  initial begin
    // re, we, adr0, adr1, dw0, dw1, wait, pdr, e_ack, e_adr, e_dw, e_we, e_re
    vecs[0] = '{2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2, 32'h1234_5678,
                2'b01, 32'h100, 32'h0, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 2'b10, 32'h0, 32'h2004, 32'h0, 32'hCAFE_F00D, 0, 32'h0000_5A5A,
                2'b10, 32'h2004, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 2'b01, 32'h300, 32'h0, 32'h55AA_55AA, 32'h0, 1, 32'h1111_2222,
                2'b01, 32'h300, 32'h55AA_55AA, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'hD0, 32'hD1, 0, 32'h3333_4444,
                2'b10, 32'h20, 32'hD1, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'hD0, 32'hD1, 0, 32'h5555_6666,
                2'b01, 32'h10, 32'hD0, 1'b0, 1'b1};
    vecs[5] = '{2'b10, 2'b01, 32'h40, 32'h44, 32'h77, 32'h88, 3, 32'h7777_8888,
                2'b10, 32'h44, 32'h88, 1'b0, 1'b1};

    xreset = 1'b0;
    req_re = '0; req_we = '0; req_adr = '0; req_dw = '0;
    p_dr = '0; p_ack = 1'b0;
    repeat (2) @(negedge cclk);
    chk("reset p_we|p_re", 32'(p_we | p_re), 32'(0));
    chk("reset p_adr", p_adr, 32'h0);
    chk("reset p_dw", p_dw, 32'h0);
    chk("reset req_ack", 32'(req_ack), 32'(0));
    chk("reset req_dr", req_dr, 32'h0);
    chk("reset tmo_err", 32'(tmo_err), 32'(0));
    xreset = 1'b1;
    @(negedge cclk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Both masters request continuously; the core acks at once
    req_re  = 2'b11;
    req_we  = 2'b00;
    req_adr = {32'hA1, 32'hA0};
    n_gnt   = 0;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      if (req_ack == 2'b01) begin grants[n_gnt] = 0; n_gnt++; end
      else if (req_ack == 2'b10) begin grants[n_gnt] = 1; n_gnt++; end
      if (n_gnt < 4) begin
        p_ack = p_re;
        @(posedge cclk); @(negedge cclk);
      end
    end
    req_re = '0;
    p_ack  = 1'b0;
    chk("alternation grant count", 32'(n_gnt), 32'(4));
    for (int k = 0; k < n_gnt; k++)
      chk($sformatf("alternation grant %0d", k), 32'(grants[k]), 32'(k % 2));
    repeat (2) @(negedge cclk);

    // Reset while master 0 owns the bus; afterwards master 0 must still win first
    req_re  = 2'b01;
    req_adr = {32'hB1, 32'hB0};
    @(posedge cclk); @(negedge cclk);
    chk("pre-reset p_re", 32'(p_re), 32'(1));
    xreset = 1'b0;
    #1;
    chk("mid reset p_re", 32'(p_re), 32'(0));
    chk("mid reset p_we", 32'(p_we), 32'(0));
    chk("mid reset req_ack", 32'(req_ack), 32'(0));
    chk("mid reset req_dr", req_dr, 32'h0);
    chk("mid reset p_adr", p_adr, 32'h0);
    req_re = 2'b11;
    @(negedge cclk);
    xreset = 1'b1;
    @(posedge cclk); @(negedge cclk);
    chk("post-reset first grant adr", p_adr, 32'hB0);
    p_ack = 1'b1;
    p_dr  = 32'h0000_00B0;
    @(posedge cclk); @(negedge cclk);
    p_ack = 1'b0;
    chk("post-reset req_ack", 32'(req_ack), 32'(2'b01));
    req_re = '0;
    repeat (2) @(negedge cclk);

`ifdef RV_PBUS_ARB_TIMEOUT_EN
    // Core never acks: watchdog completes after TMO BUSY cycles
    req_re  = 2'b01;
    req_adr = {32'hC1, 32'hC0};
    busy_cyc = 0;
    got_ack  = 1'b0;
    @(posedge cclk); @(negedge cclk);
    for (int c = 0; c < 40 && !got_ack; c++) begin
      if (req_ack != '0) got_ack = 1'b1;
      else begin
        if (p_re) busy_cyc++;
        @(posedge cclk); @(negedge cclk);
      end
    end
    chk("tmo busy cycles", 32'(busy_cyc), 32'(TMO));
    chk("tmo req_ack", 32'(req_ack), 32'(2'b01));
    chk("tmo req_dr", req_dr, 32'hDEAD_BEEF);
    chk("tmo tmo_err", 32'(tmo_err), 32'(1));
    req_re = '0;
    repeat (2) @(negedge cclk);
    // Ack arriving on the very cycle the count reaches TMO wins
    vw = '{2'b10, 2'b00, 32'h0, 32'hE4, 32'h0, 32'h0, TMO - 1, 32'h0BAD_F00D,
           2'b10, 32'hE4, 32'h0, 1'b0, 1'b1};
    run_vec(6, vw);
    chk("tmo_err sticky", 32'(tmo_err), 32'(1));
`else
    // Without the watchdog BUSY waits indefinitely
    req_re  = 2'b01;
    req_adr = {32'hC1, 32'hC0};
    busy_cyc = 0;
    @(posedge cclk); @(negedge cclk);
    for (int c = 0; c < 40; c++) begin
      if (p_re && req_ack == '0) busy_cyc++;
      @(posedge cclk); @(negedge cclk);
    end
    chk("no-tmo still busy", 32'(busy_cyc), 32'(40));
    p_ack = 1'b1;
    p_dr  = 32'h0C0C_0C0C;
    @(posedge cclk); @(negedge cclk);
    p_ack = 1'b0;
    chk("no-tmo late req_ack", 32'(req_ack), 32'(2'b01));
    chk("no-tmo late req_dr", req_dr, 32'h0C0C_0C0C);
    chk("no-tmo tmo_err", 32'(tmo_err), 32'(0));
    req_re = '0;
    repeat (2) @(negedge cclk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
